// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline.
//  - WB control bit positions (RegWrite, MemtoReg)
//  - M control bit positions (MemRead, MemWrite, Branch)
//  - Data-memory bus FSM state encoding
//  - Word-alignment helper for byte addresses
package pipeline_pkg;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    localparam int M_MEMREAD  = 0;
    localparam int M_MEMWRITE = 1;
    localparam int M_BRANCH   = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    // A byte address is word aligned when its two low bits are zero.
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller for the MEM stage.
// Holds a single outstanding req/ack transaction and bounds it with a timeout.
// Ports:
//  clk, rst          clock / synchronous active-high reset
//  start             begin an access (only honoured in IDLE)
//  we, addr, wdata   access parameters, latched on start
//  dmem_ack          bus completion (ignored outside ACCESS)
//  idle              FSM is in IDLE
//  done              ACCESS and dmem_ack this cycle
//  timeout           ACCESS, no ack, and the wait budget is exhausted
//  busy              ACCESS still waiting (neither done nor timeout)
//  dmem_req/we/addr/wdata  bus request signals, stable for the whole access
module mem_bus_ctrl
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              dmem_ack,
    output logic              idle,
    output logic              done,
    output logic              timeout,
    output logic              busy,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == IDLE && start) begin
                we_reg    <= we;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done       = 1'b0;
        timeout    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    done       = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    // Counter counts ACCESS cycles from 0, so this is the
                    // TIMEOUT-th cycle the request has been held.
                    timeout    = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign idle       = (state_reg == IDLE);
    assign busy       = (state_reg == ACCESS) && !done && !timeout;
    assign dmem_req   = (state_reg == ACCESS);
    assign dmem_we    = we_reg;
    assign dmem_addr  = addr_reg;
    assign dmem_wdata = wdata_reg;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline.
// Takes the EX/MEM entry, performs the data-memory access over a req/ack bus,
// stalls the front of the pipe while an access is outstanding, resolves branches
// and writes the MEM/WB register.
// Ports:
//  clk, rst                 clock / synchronous active-high reset
//  i_valid, i_wb, i_mem_read, i_mem_write, i_branch, i_branch_target,
//  i_zero, i_alu_result, i_wdata, i_dst_reg     EX/MEM register contents
//  o_stall                  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//  o_pc_src, o_branch_target  branch resolution
//  dmem_req/we/addr/wdata, dmem_ack, dmem_rdata  data-memory bus
//  o_valid, o_wb, o_rdata, o_alu_result, o_dst_reg, o_exc  MEM/WB register
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [1:0]        i_wb,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_branch,
    input  logic [31:0]       i_branch_target,
    input  logic              i_zero,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_W-1:0]  i_dst_reg,
    output logic              o_stall,
    output logic              o_pc_src,
    output logic [31:0]       o_branch_target,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              o_valid,
    output logic [1:0]        o_wb,
    output logic [DATA_W-1:0] o_rdata,
    output logic [DATA_W-1:0] o_alu_result,
    output logic [REG_W-1:0]  o_dst_reg,
    output logic              o_exc
);

    logic mem_op;
    logic aligned;
    logic start;
    logic misaligned;
    logic bus_idle;
    logic bus_done;
    logic bus_timeout;
    logic bus_busy;

    // A load and store flagged together is treated as a store.
    assign mem_op     = i_valid && (i_mem_read || i_mem_write);
    assign aligned    = is_word_aligned(i_alu_result[1:0]);
    assign start      = bus_idle && mem_op && aligned;
    assign misaligned = bus_idle && mem_op && !aligned;

    mem_bus_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_bus (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .we         (i_mem_write),
        .addr       (i_alu_result[ADDR_W-1:0]),
        .wdata      (i_wdata),
        .dmem_ack   (dmem_ack),
        .idle       (bus_idle),
        .done       (bus_done),
        .timeout    (bus_timeout),
        .busy       (bus_busy),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata)
    );

    assign o_stall         = start || bus_busy;
    // EX/MEM is frozen during ACCESS, so a branch there would be stale.
    assign o_pc_src        = i_valid && i_branch && i_zero && bus_idle;
    assign o_branch_target = i_branch_target;

    // Entry fields captured at access start, replayed into MEM/WB on completion.
    logic [1:0]        wb_lat_reg;
    logic [REG_W-1:0]  dst_lat_reg;
    logic [DATA_W-1:0] alu_lat_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_lat_reg   <= '0;
            dst_lat_reg  <= '0;
            alu_lat_reg  <= '0;
            o_valid      <= 1'b0;
            o_wb         <= '0;
            o_rdata      <= '0;
            o_alu_result <= '0;
            o_dst_reg    <= '0;
            o_exc        <= 1'b0;
        end else if (bus_idle) begin
            o_rdata <= '0;
            if (start) begin
                wb_lat_reg  <= i_wb;
                dst_lat_reg <= i_dst_reg;
                alu_lat_reg <= i_alu_result;
                o_valid     <= 1'b0;
                o_exc       <= 1'b0;
            end else if (misaligned) begin
                // Faulting access: deliver the entry with RegWrite suppressed.
                o_valid      <= 1'b1;
                o_wb         <= {i_wb[WB_MEMTOREG], 1'b0};
                o_alu_result <= i_alu_result;
                o_dst_reg    <= i_dst_reg;
                o_exc        <= 1'b1;
            end else begin
                o_valid      <= i_valid;
                o_wb         <= i_wb;
                o_alu_result <= i_alu_result;
                o_dst_reg    <= i_dst_reg;
                o_exc        <= 1'b0;
            end
        end else if (bus_done) begin
            o_valid      <= 1'b1;
            o_wb         <= wb_lat_reg;
            o_rdata      <= dmem_we ? '0 : dmem_rdata;
            o_alu_result <= alu_lat_reg;
            o_dst_reg    <= dst_lat_reg;
            o_exc        <= 1'b0;
        end else if (bus_timeout) begin
            o_valid      <= 1'b1;
            o_wb         <= {wb_lat_reg[WB_MEMTOREG], 1'b0};
            o_rdata      <= '0;
            o_alu_result <= alu_lat_reg;
            o_dst_reg    <= dst_lat_reg;
            o_exc        <= 1'b1;
        end else begin
            // Still waiting: push a bubble into WB.
            o_valid <= 1'b0;
            o_exc   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [1:0]  i_wb;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_branch;
    logic [31:0] i_branch_target;
    logic        i_zero;
    logic [31:0] i_alu_result;
    logic [31:0] i_wdata;
    logic [4:0]  i_dst_reg;
    logic        o_stall;
    logic        o_pc_src;
    logic [31:0] o_branch_target;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        o_valid;
    logic [1:0]  o_wb;
    logic [31:0] o_rdata;
    logic [31:0] o_alu_result;
    logic [4:0]  o_dst_reg;
    logic        o_exc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .REG_W   (5),
        .TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_valid         (i_valid),
        .i_wb            (i_wb),
        .i_mem_read      (i_mem_read),
        .i_mem_write     (i_mem_write),
        .i_branch        (i_branch),
        .i_branch_target (i_branch_target),
        .i_zero          (i_zero),
        .i_alu_result    (i_alu_result),
        .i_wdata         (i_wdata),
        .i_dst_reg       (i_dst_reg),
        .o_stall         (o_stall),
        .o_pc_src        (o_pc_src),
        .o_branch_target (o_branch_target),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .o_valid         (o_valid),
        .o_wb            (o_wb),
        .o_rdata         (o_rdata),
        .o_alu_result    (o_alu_result),
        .o_dst_reg       (o_dst_reg),
        .o_exc           (o_exc)
    );

    // Advance one clock and land 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        i_valid         = 1'b0;
        i_wb            = 2'b00;
        i_mem_read      = 1'b0;
        i_mem_write     = 1'b0;
        i_branch        = 1'b0;
        i_branch_target = 32'h0;
        i_zero          = 1'b0;
        i_alu_result    = 32'h0;
        i_wdata         = 32'h0;
        i_dst_reg       = 5'd0;
    endtask

    initial begin
        int req_cnt;
        int stall_cnt;

        // ---------------- reset ----------------
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_req",   dmem_req, 0);
        check("rst_stall", o_stall, 0);
        check("rst_exc",   o_exc, 0);
        check("rst_rdata", o_rdata, 0);
        $display("[TB] reset done");

        // ---------------- ALU op, no memory ----------------
        i_valid = 1'b1; i_wb = 2'b01; i_alu_result = 32'h1234; i_dst_reg = 5'd5;
        #1;
        check("alu_stall", o_stall, 0);
        check("alu_req",   dmem_req, 0);
        tick();
        check("alu_valid", o_valid, 1);
        check("alu_res",   o_alu_result, 32'h1234);
        check("alu_dst",   o_dst_reg, 5);
        check("alu_wb",    o_wb, 2'b01);
        check("alu_rdata", o_rdata, 0);
        $display("[TB] alu op alu=0x%08h valid=%0b", o_alu_result, o_valid);

        // ---------------- load 0x100, ack on third request cycle ----------------
        i_valid = 1'b1; i_mem_read = 1'b1; i_alu_result = 32'h100; i_wb = 2'b11; i_dst_reg = 5'd7;
        #1;
        check("ld_stall0", o_stall, 1);
        check("ld_req0",   dmem_req, 0);
        tick();
        check("ld_valid1", o_valid, 0);
        check("ld_req1",   dmem_req, 1);
        check("ld_we1",    dmem_we, 0);
        check("ld_addr1",  dmem_addr, 32'h100);
        check("ld_stall1", o_stall, 1);
        tick();
        check("ld_req2",   dmem_req, 1);
        check("ld_stall2", o_stall, 1);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        check("ld_req3",   dmem_req, 1);
        check("ld_stall3", o_stall, 0);
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        idle_inputs();
        check("ld_valid",  o_valid, 1);
        check("ld_rdata",  o_rdata, 32'hDEADBEEF);
        check("ld_wb",     o_wb, 2'b11);
        check("ld_dst",    o_dst_reg, 7);
        check("ld_reqoff", dmem_req, 0);
        $display("[TB] load addr=0x100 rdata=0x%08h valid=%0b", o_rdata, o_valid);

        // ---------------- store 0x104, ack in first request cycle ----------------
        i_valid = 1'b1; i_mem_write = 1'b1; i_alu_result = 32'h104; i_wdata = 32'hA5A5A5A5;
        i_dst_reg = 5'd9;
        #1;
        check("st_stall0", o_stall, 1);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
        #1;
        check("st_req",    dmem_req, 1);
        check("st_we",     dmem_we, 1);
        check("st_addr",   dmem_addr, 32'h104);
        check("st_wdata",  dmem_wdata, 32'hA5A5A5A5);
        check("st_stall1", o_stall, 0);
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        idle_inputs();
        check("st_valid",  o_valid, 1);
        check("st_rdata",  o_rdata, 0);
        check("st_alu",    o_alu_result, 32'h104);
        $display("[TB] store addr=0x104 valid=%0b rdata=0x%08h", o_valid, o_rdata);

        // ---------------- misaligned load 0x102 ----------------
        i_valid = 1'b1; i_mem_read = 1'b1; i_alu_result = 32'h102; i_wb = 2'b11; i_dst_reg = 5'd3;
        #1;
        check("mis_stall", o_stall, 0);
        check("mis_req0",  dmem_req, 0);
        tick();
        idle_inputs();
        check("mis_req1",  dmem_req, 0);
        check("mis_valid", o_valid, 1);
        check("mis_exc",   o_exc, 1);
        check("mis_wb",    o_wb, 2'b10);
        tick();
        check("mis_excpulse", o_exc, 0);
        $display("[TB] misaligned load addr=0x102 handled");

        // ---------------- load with no ack -> timeout ----------------
        i_valid = 1'b1; i_mem_read = 1'b1; i_alu_result = 32'h200; i_wb = 2'b11; i_dst_reg = 5'd4;
        #1;
        check("to_stall0", o_stall, 1);
        tick();
        req_cnt   = 0;
        stall_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (dmem_req) req_cnt++;
            if (o_stall)  stall_cnt++;
            tick();
        end
        idle_inputs();
        check("to_reqcycles",   req_cnt, 16);
        check("to_stallcycles", stall_cnt, 15);
        check("to_valid",       o_valid, 1);
        check("to_exc",         o_exc, 1);
        check("to_wb",          o_wb, 2'b10);
        check("to_rdata",       o_rdata, 0);
        check("to_reqoff",      dmem_req, 0);
        // Late ack arriving in IDLE must be ignored.
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1;
        check("late_stall", o_stall, 0);
        tick();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        check("late_valid", o_valid, 0);
        check("late_exc",   o_exc, 0);
        check("late_req",   dmem_req, 0);
        $display("[TB] timeout load addr=0x200 req_cycles=%0d", req_cnt);

        // ---------------- branch in IDLE ----------------
        i_valid = 1'b1; i_branch = 1'b1; i_zero = 1'b1; i_branch_target = 32'h4000;
        #1;
        check("br_pcsrc",  o_pc_src, 1);
        check("br_target", o_branch_target, 32'h4000);
        i_zero = 1'b0;
        #1;
        check("br_nz_pcsrc", o_pc_src, 0);
        tick();
        idle_inputs();
        $display("[TB] branch target=0x%08h", o_branch_target);

        // ---------------- reset during ACCESS ----------------
        i_valid = 1'b1; i_mem_read = 1'b1; i_alu_result = 32'h300; i_wb = 2'b11;
        tick();
        i_branch = 1'b1; i_zero = 1'b1; i_branch_target = 32'h8000;
        #1;
        check("rsta_req",   dmem_req, 1);
        check("rsta_pcsrc", o_pc_src, 0);
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        check("rsta_reqoff", dmem_req, 0);
        check("rsta_valid",  o_valid, 0);
        tick();
        check("rsta_valid2", o_valid, 0);
        check("rsta_exc",    o_exc, 0);
        check("rsta_req2",   dmem_req, 0);
        $display("[TB] reset during access req=%0b valid=%0b", dmem_req, o_valid);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
